// File: rtl/day_tick_pkg.sv
// Shared constants and types for the day-of-year tick control path.
// Defaults assume the 10 MHz ADC_CLK_10 board clock.
package day_tick_pkg;

    localparam int CLK_HZ       = 10_000_000;
    localparam int SLOW_DIV_DEF = CLK_HZ;
    localparam int FAST_DIV_DEF = CLK_HZ / 10;
    localparam int DEBOUNCE_DEF = CLK_HZ / 50;

    typedef enum logic {
        RATE_SLOW = 1'b0,
        RATE_FAST = 1'b1
    } rate_t;

endpackage

// File: rtl/day_tick_ctrl_if.sv
// Bundle between the tick control stage and the day counter / board pins.
// master: control stage (reads key_n, drives tick/count_clear/fast/rate_led).
interface day_tick_ctrl_if;

    logic [1:0] key_n;
    logic       tick;
    logic       count_clear;
    logic       fast;
    logic       rate_led;

    modport master (
        input  key_n,
        output tick,
        output count_clear,
        output fast,
        output rate_led
    );

    modport slave (
        output key_n,
        input  tick,
        input  count_clear,
        input  fast,
        input  rate_led
    );

endinterface

// File: rtl/day_tick_ctrl_key_debounce.sv
// One push-button: 2-FF synchronizer, stability counter, debounced level.
// Ports: clk, reset, key_n (raw, active-low), press (comb pulse, 1->0 accept).
module key_debounce
    import day_tick_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES);

    logic          sync_a;
    logic          sync_b;
    logic          level_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a  <= 1'b1;
            sync_b  <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync_a <= key_n;
            sync_b <= sync_a;
            if (sync_b == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_q   <= '0;
                level_q <= sync_b;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // High in the cycle whose edge flips the level from released to pressed;
    // the top registers it, so outputs stay register-driven.
    assign press = level_q && !sync_b && (cnt_q == CNT_LAST);

endmodule

// File: rtl/day_tick_ctrl.sv
// Day-advance tick generator: debounced clear/rate keys, slow/fast prescaler.
// Ports: clk, reset, bus (key_n in; tick, count_clear, fast, rate_led out),
// hold (only when DAY_TICK_HOLD_EN is defined: freezes the prescaler).
module day_tick_ctrl
    import day_tick_pkg::*;
#(
    parameter int SLOW_DIV        = SLOW_DIV_DEF,
    parameter int FAST_DIV        = FAST_DIV_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
    input  logic clk,
    input  logic reset,
`ifdef DAY_TICK_HOLD_EN
    input  logic hold,
`endif
    day_tick_ctrl_if.master bus
);

    localparam int PW = $clog2(SLOW_DIV);
    localparam logic [PW-1:0] SLOW_LAST = PW'(SLOW_DIV - 1);
    localparam logic [PW-1:0] FAST_LAST = PW'(FAST_DIV - 1);

    logic          press_clr;
    logic          press_rate;
    logic          hold_w;
    rate_t         rate_q;
    rate_t         rate_d;
    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;
    logic [PW-1:0] div_last;
    logic          tick_d;
    logic          tick_q;
    logic          clear_q;
    logic          led_q;

`ifdef DAY_TICK_HOLD_EN
    assign hold_w = hold;
`else
    assign hold_w = 1'b0;
`endif

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_clr (
        .clk  (clk),
        .reset(reset),
        .key_n(bus.key_n[0]),
        .press(press_clr)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_rate (
        .clk  (clk),
        .reset(reset),
        .key_n(bus.key_n[1]),
        .press(press_rate)
    );

    always_comb begin
        rate_d = rate_q;
        if (press_rate) begin
            rate_d = (rate_q == RATE_SLOW) ? RATE_FAST : RATE_SLOW;
        end
    end

    // Any key action restarts the period, which also suppresses a tick
    // that would otherwise land in a clear cycle.
    always_comb begin
        div_last = (rate_q == RATE_FAST) ? FAST_LAST : SLOW_LAST;
        pre_d    = pre_q;
        tick_d   = 1'b0;
        if (press_clr || press_rate) begin
            pre_d = '0;
        end else if (hold_w) begin
            pre_d = pre_q;
        end else if (pre_q >= div_last) begin
            pre_d  = '0;
            tick_d = 1'b1;
        end else begin
            pre_d = pre_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rate_q  <= RATE_SLOW;
            pre_q   <= '0;
            tick_q  <= 1'b0;
            clear_q <= 1'b0;
            led_q   <= 1'b0;
        end else begin
            rate_q  <= rate_d;
            pre_q   <= pre_d;
            tick_q  <= tick_d;
            clear_q <= press_clr;
            led_q   <= led_q ^ tick_d;
        end
    end

    assign bus.tick        = tick_q;
    assign bus.count_clear = clear_q;
    assign bus.fast        = (rate_q == RATE_FAST);
    assign bus.rate_led    = led_q;

endmodule

// File: tb/tb_day_tick_ctrl.sv
// Directed bench for day_tick_ctrl with SLOW_DIV=10, FAST_DIV=4, DEBOUNCE=3.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_day_tick_ctrl;

    logic clk;
    logic reset;
`ifdef DAY_TICK_HOLD_EN
    logic hold;
`endif
    int n_run;
    int n_fail;

    day_tick_ctrl_if bus ();

    day_tick_ctrl #(
        .SLOW_DIV       (10),
        .FAST_DIV       (4),
        .DEBOUNCE_CYCLES(3)
    ) dut (
        .clk  (clk),
        .reset(reset),
`ifdef DAY_TICK_HOLD_EN
        .hold (hold),
`endif
        .bus  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.key_n = 2'b11;
`ifdef DAY_TICK_HOLD_EN
        hold = 1'b0;
`endif
        step(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.key_n = 2'b11;
`ifdef DAY_TICK_HOLD_EN
        hold = 1'b0;
`endif
        step(2);
        n_run++;
        if ({bus.tick, bus.count_clear, bus.fast, bus.rate_led} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outs got=%b want=0000",
                {bus.tick, bus.count_clear, bus.fast, bus.rate_led});
        end
        reset = 1'b0;
    endtask

    task automatic test_free_run();
        logic exp_tick;
        logic exp_led;
        do_reset();
        for (int i = 1; i <= 40; i++) begin
            step(1);
            exp_tick = (i % 10 == 0);
            exp_led = ((i / 10) % 2) == 1;
            n_run++;
            if (bus.tick !== exp_tick) begin
                n_fail++;
                $display("FAIL free_tick cyc=%0d got=%b want=%b",
                    i, bus.tick, exp_tick);
            end
            n_run++;
            if (bus.rate_led !== exp_led) begin
                n_fail++;
                $display("FAIL free_led cyc=%0d got=%b want=%b",
                    i, bus.rate_led, exp_led);
            end
        end
        n_run++;
        if (bus.fast !== 1'b0) begin
            n_fail++;
            $display("FAIL free_fast got=%b want=0", bus.fast);
        end
    endtask

    task automatic test_rate_toggle();
        logic exp;
        do_reset();
        bus.key_n = 2'b01;
        for (int i = 1; i <= 6; i++) begin
            step(1);
            exp = (i >= 6);
            n_run++;
            if (bus.fast !== exp) begin
                n_fail++;
                $display("FAIL rate_fast cyc=%0d got=%b want=%b",
                    i, bus.fast, exp);
            end
            n_run++;
            if (bus.tick !== 1'b0) begin
                n_fail++;
                $display("FAIL rate_pre_tick cyc=%0d got=%b want=0",
                    i, bus.tick);
            end
        end
        for (int j = 1; j <= 12; j++) begin
            step(1);
            exp = (j % 4 == 0);
            n_run++;
            if (bus.tick !== exp) begin
                n_fail++;
                $display("FAIL rate_fast_tick cyc=%0d got=%b want=%b",
                    j, bus.tick, exp);
            end
        end
        n_run++;
        if (bus.rate_led !== 1'b1) begin
            n_fail++;
            $display("FAIL rate_led got=%b want=1", bus.rate_led);
        end
        bus.key_n = 2'b11;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            n_run++;
            if (bus.fast !== 1'b1) begin
                n_fail++;
                $display("FAIL rate_release cyc=%0d got=%b want=1",
                    k, bus.fast);
            end
        end
    endtask

    // Clear lands on the edge where the slow tick would have fired (20th).
    task automatic test_bounce_clear();
        int clears;
        logic exp;
        clears = 0;
        do_reset();
        step(2);
        for (int i = 0; i < 12; i++) begin
            bus.key_n = {1'b1, ((i / 2) % 2) == 1};
            step(1);
            if (bus.count_clear === 1'b1) clears++;
        end
        bus.key_n = 2'b10;
        for (int i = 1; i <= 6; i++) begin
            step(1);
            if (bus.count_clear === 1'b1) clears++;
            exp = (i == 6);
            n_run++;
            if (bus.count_clear !== exp) begin
                n_fail++;
                $display("FAIL bounce_clear cyc=%0d got=%b want=%b",
                    i, bus.count_clear, exp);
            end
        end
        n_run++;
        if (bus.tick !== 1'b0) begin
            n_fail++;
            $display("FAIL bounce_tick_in_clear got=%b want=0", bus.tick);
        end
        for (int j = 1; j <= 10; j++) begin
            step(1);
            if (bus.count_clear === 1'b1) clears++;
            exp = (j == 10);
            n_run++;
            if (bus.tick !== exp) begin
                n_fail++;
                $display("FAIL bounce_next_tick cyc=%0d got=%b want=%b",
                    j, bus.tick, exp);
            end
        end
        n_run++;
        if (clears != 1) begin
            n_fail++;
            $display("FAIL bounce_count got=%0d want=1", clears);
        end
        bus.key_n = 2'b11;
        step(8);
    endtask

    task automatic test_both_keys();
        logic exp;
        do_reset();
        bus.key_n = 2'b00;
        step(5);
        n_run++;
        if ({bus.count_clear, bus.fast} !== 2'b00) begin
            n_fail++;
            $display("FAIL both_early got=%b want=00",
                {bus.count_clear, bus.fast});
        end
        step(1);
        n_run++;
        if ({bus.count_clear, bus.fast, bus.tick} !== 3'b110) begin
            n_fail++;
            $display("FAIL both_accept got=%b want=110",
                {bus.count_clear, bus.fast, bus.tick});
        end
        for (int j = 1; j <= 8; j++) begin
            step(1);
            exp = (j % 4 == 0);
            n_run++;
            if (bus.tick !== exp) begin
                n_fail++;
                $display("FAIL both_tick cyc=%0d got=%b want=%b",
                    j, bus.tick, exp);
            end
        end
        bus.key_n = 2'b11;
        step(8);
    endtask

    task automatic test_reset_mid();
        logic exp;
        do_reset();
        step(5);
        bus.key_n = 2'b01;
        step(2);
        reset = 1'b1;
        step(1);
        n_run++;
        if ({bus.tick, bus.count_clear, bus.fast, bus.rate_led} !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_reset_outs got=%b want=0000",
                {bus.tick, bus.count_clear, bus.fast, bus.rate_led});
        end
        step(1);
        reset = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step(1);
            exp = (i >= 6);
            n_run++;
            if (bus.fast !== exp) begin
                n_fail++;
                $display("FAIL mid_fast cyc=%0d got=%b want=%b",
                    i, bus.fast, exp);
            end
        end
        bus.key_n = 2'b11;
        step(8);
    endtask

`ifdef DAY_TICK_HOLD_EN
    task automatic test_hold();
        logic exp;
        do_reset();
        step(6);
        hold = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            step(1);
            n_run++;
            if (bus.tick !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_tick cyc=%0d got=%b want=0", i, bus.tick);
            end
        end
        hold = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            step(1);
            exp = (j == 4);
            n_run++;
            if (bus.tick !== exp) begin
                n_fail++;
                $display("FAIL hold_resume cyc=%0d got=%b want=%b",
                    j, bus.tick, exp);
            end
        end
    endtask
`endif

    initial begin
        n_run = 0;
        n_fail = 0;
        reset = 1'b1;
        bus.key_n = 2'b11;
`ifdef DAY_TICK_HOLD_EN
        hold = 1'b0;
`endif
        test_reset();
        test_free_run();
        test_rate_toggle();
        test_bounce_clear();
        test_both_keys();
        test_reset_mid();
`ifdef DAY_TICK_HOLD_EN
        test_hold();
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
